decade_counter_sequencer: RTL and testbench
===========================================

Name: decade_counter_sequencer

Overview:
- Controller that sequences a 1-to-10 decade count under a start/stop/pause/load command interface.
- Supports one-shot and auto-reload modes.
- Reports busy, a terminal-count done pulse, a wrap counter and a range-error flag.
- Sits between the control logic and the decade counting datapath. It owns the count register and all sequencing decisions.

Parameters:
- MIN_VAL, 1, lowest count value; reload target.
- MAX_VAL, 10, terminal count value.
- CNT_W, 4, count width.
- WRAP_W, 8, width of the wrap counter.
- PRESCALE, 4, tick divisor. Used only with DECADE_SEQ_PRESCALE_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin counting. Sampled only in IDLE.
- stop  in  1  abort. Returns to IDLE with no done pulse.
- pause  in  1  level. Holds count while high.
- load  in  1  load load_val into count. Honoured in IDLE and PAUSE only.
- load_val  in  CNT_W  value for load.
- auto_reload  in  1  1 = wrap MAX_VAL->MIN_VAL and keep running; 0 = one-shot.
- count  out  CNT_W  current count.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  one-cycle pulse on one-shot completion.
- wrap_cnt  out  WRAP_W  number of auto-reload wraps since the last start.
- err  out  1  sticky flag: a load was attempted with an out-of-range value.

Behaviour:
- Reset (async, immediate): state=IDLE, count=MIN_VAL, busy=0, done=0, wrap_cnt=0, err=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered. busy = (state==RUN || state==PAUSE). done = (state==DONE).
- IDLE:
  - stop has priority over start.
  - start -> RUN. On the same edge: wrap_cnt<=0, err<=0.
  - load with MIN_VAL<=load_val<=MAX_VAL -> count<=load_val.
  - load with load_val out of range -> err<=1; count unchanged.
  - load and start in the same cycle: the load is applied, then RUN begins from the loaded value.
- RUN, per tick, with priority stop > pause > count:
  - stop -> IDLE, count<=MIN_VAL.
  - pause -> PAUSE; no increment on that edge.
  - count<MAX_VAL -> count+1.
  - count==MAX_VAL and auto_reload=1 -> count<=MIN_VAL, wrap_cnt+1 (saturates at all-ones); stay in RUN.
  - count==MAX_VAL and auto_reload=0 -> DONE; count holds MAX_VAL.
  - load is ignored in RUN.
- PAUSE:
  - stop -> IDLE, count<=MIN_VAL.
  - load is legal, with the same range check as IDLE.
  - pause low -> RUN; the next increment occurs on the following edge.
- DONE: lasts exactly one cycle -> IDLE with count<=MIN_VAL. All inputs are ignored.
- start while busy is ignored.
- Timing: start sampled at edge k -> busy=1 after k; first increment at k+1. From count=1, count=10 after k+9, done=1 after k+10, IDLE with count=1 after k+11.
- Count never leaves [MIN_VAL, MAX_VAL]. Arithmetic is unsigned, CNT_W bits.

Optional Feature:
- Macro: DECADE_SEQ_PRESCALE_EN.
- Defined:
  - A tick occurs every PRESCALE clocks in RUN, driven by an internal prescaler.
  - The prescaler clears on entry to RUN, including resume from PAUSE, and holds in IDLE and PAUSE.
  - stop and pause still act on the very next edge, independent of the tick.
- Undefined: a tick occurs every clock in RUN; no prescaler logic is present.

Test Plan:
- Reset, auto_reload=0, start pulse -> count 1,2,...,10 on successive edges; done high exactly one cycle after 10; then count=1, busy=0.
- auto_reload=1, start, run 25 increments -> count sequence 10->1 twice; wrap_cnt=2; done never asserted; start again clears wrap_cnt to 0.
- In IDLE: load_val=7, then start -> 7,8,9,10 then done. load_val=0 -> err=1, count unchanged. load_val=11 -> err=1, count unchanged. Next start clears err.
- Pause held 3 cycles at count=5 -> count stays 5 and busy=1 throughout. Load 3 during PAUSE, release pause -> 4 on the following edge.
- stop at count=8 -> IDLE, count=1, no done. start and stop in the same IDLE cycle -> stays IDLE, busy=0.
- Assert reset between clock edges during RUN at count=6 -> count=1, busy=0, wrap_cnt=0 immediately, before the next edge. With DECADE_SEQ_PRESCALE_EN and PRESCALE=4 -> increments every 4 clocks.

Source files
------------

// File: rtl/decade_counter_sequencer.sv
// Decade count sequencer: start/stop/pause/load control over a MIN..MAX count.
// Optional tick prescaler is enabled with `define DECADE_SEQ_PRESCALE_EN.
module decade_counter_sequencer #(
  parameter int MIN_VAL  = 1,
  parameter int MAX_VAL  = 10,
  parameter int CNT_W    = 4,
  parameter int WRAP_W   = 8,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              auto_reload,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MINV = CNT_W'(MIN_VAL);
  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_VAL);

  state_t state, state_n;
  logic   in_rng;
  logic   go;
  logic   tick;
  logic   busy_n;
  logic   done_n;

  if (PRESCALE < 1) begin : g_prescale_range
    $error("PRESCALE must be at least 1");
  end

  assign in_rng = (load_val >= MINV) && (load_val <= MAXV);
  assign go     = (state == IDLE) && start && !stop;

`ifdef DECADE_SEQ_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] psc;

  assign tick = (psc == PS_W'(PRESCALE - 1));

  // Restart the divider on every entry to RUN, freeze it elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc <= '0;
    end else if (state_n == RUN && state != RUN) begin
      psc <= '0;
    end else if (state == RUN) begin
      psc <= tick ? '0 : psc + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (go) state_n = RUN;
      end
      RUN: begin
        if (stop)       state_n = IDLE;
        else if (pause) state_n = PAUSE;
        else if (tick && count >= MAXV && !auto_reload)
          state_n = DONE;
      end
      PAUSE: begin
        if (stop)        state_n = IDLE;
        else if (!pause) state_n = RUN;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy_n = (state_n == RUN) || (state_n == PAUSE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= MINV;
      wrap_cnt <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= busy_n;
      done <= done_n;
      unique case (state)
        IDLE: begin
          if (load) begin
            if (in_rng) count <= load_val;
            else        err   <= 1'b1;
          end
          // A bad load in the start cycle still leaves err set.
          if (go) begin
            wrap_cnt <= '0;
            err      <= load && !in_rng;
          end
        end
        RUN: begin
          if (stop) begin
            count <= MINV;
          end else if (!pause && tick) begin
            if (count < MAXV) begin
              count <= count + 1'b1;
            end else if (auto_reload) begin
              count <= MINV;
              if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            count <= MINV;
          end else if (load) begin
            if (in_rng) count <= load_val;
            else        err   <= 1'b1;
          end
        end
        DONE: count <= MINV;
        default: count <= MINV;
      endcase
    end
  end

endmodule

// File: tb/tb_decade_counter_sequencer.sv
// Bench for decade_counter_sequencer: vector table, corner sequences,
// and random traffic against a behavioural model.
module tb_decade_counter_sequencer;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, pause, load, auto_reload;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       busy, done, err;
  logic [7:0] wrap_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bit m_run, m_pause, m_done, m_err;
  int m_cnt, m_wrap, m_ps;

  typedef struct {
    bit         st, sp, pa, ld;
    logic [3:0] lv;
    bit         ar;
    logic [3:0] ec;
    bit         eb, ed;
    logic [7:0] ew;
    bit         ee;
  } vec_t;

  vec_t tbl[$];

  decade_counter_sequencer #(
    .MIN_VAL(1), .MAX_VAL(10), .CNT_W(4),
    .WRAP_W(8), .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .stop(stop), .pause(pause), .load(load),
    .load_val(load_val), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done),
    .wrap_cnt(wrap_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_pause = 0; m_done = 0; m_err = 0;
    m_cnt = 1; m_wrap = 0; m_ps = 0;
  endtask

  // Spec rules applied to the inputs present at the last edge.
  task automatic model_step();
    bit ok;
    bit tk;
    ok = (int'(load_val) >= 1) && (int'(load_val) <= 10);
    if (m_done) begin
      m_done = 0;
      m_cnt  = 1;
    end else if (!m_run && !m_pause) begin
      if (load) begin
        if (ok) m_cnt = int'(load_val);
        else    m_err = 1;
      end
      if (start && !stop) begin
        m_run  = 1;
        m_wrap = 0;
        m_err  = load && !ok;
        m_ps   = 0;
      end
    end else if (m_run) begin
      if (stop) begin
        m_run = 0;
        m_cnt = 1;
      end else if (pause) begin
        m_run   = 0;
        m_pause = 1;
      end else begin
`ifdef DECADE_SEQ_PRESCALE_EN
        tk   = (m_ps == PRESCALE - 1);
        m_ps = tk ? 0 : m_ps + 1;
`else
        tk = 1;
`endif
        if (tk) begin
          if (m_cnt < 10) m_cnt = m_cnt + 1;
          else if (auto_reload) begin
            m_cnt = 1;
            if (m_wrap < 255) m_wrap = m_wrap + 1;
          end else begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end
    end else begin
      if (stop) begin
        m_pause = 0;
        m_cnt   = 1;
      end else begin
        if (load) begin
          if (ok) m_cnt = int'(load_val);
          else    m_err = 1;
        end
        if (!pause) begin
          m_pause = 0;
          m_run   = 1;
          m_ps    = 0;
        end
      end
    end
  endtask

  task automatic cmp_model(string tag);
    chk({tag, " count"}, int'(count), m_cnt);
    chk({tag, " busy"}, int'(busy), int'(m_run || m_pause));
    chk({tag, " done"}, int'(done), int'(m_done));
    chk({tag, " wrap"}, int'(wrap_cnt), m_wrap);
    chk({tag, " err"}, int'(err), int'(m_err));
  endtask

  task automatic cyc(bit st, bit sp, bit pa, bit ld,
                     logic [3:0] lv, bit ar);
    start = st; stop = sp; pause = pa;
    load = ld; load_val = lv; auto_reload = ar;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic cycm(string tag, bit st, bit sp, bit pa,
                      bit ld, logic [3:0] lv, bit ar);
    cyc(st, sp, pa, ld, lv, ar);
    cmp_model(tag);
  endtask

  // Reset raised between edges must clear outputs at once.
  task automatic mid_reset(string tag);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, " async count"}, int'(count), 1);
    chk({tag, " async busy"}, int'(busy), 0);
    chk({tag, " async wrap"}, int'(wrap_cnt), 0);
    chk({tag, " async done"}, int'(done), 0);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  function automatic void add(bit st, bit sp, bit pa, bit ld,
                              logic [3:0] lv, bit ar, logic [3:0] ec,
                              bit eb, bit ed, logic [7:0] ew, bit ee);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.ld = ld;
    v.lv = lv; v.ar = ar; v.ec = ec; v.eb = eb;
    v.ed = ed; v.ew = ew; v.ee = ee;
    tbl.push_back(v);
  endfunction

  initial begin
    reset = 1'b1;
    start = 0; stop = 0; pause = 0; load = 0;
    load_val = 4'd0; auto_reload = 0;
    model_reset();
    #12;
    chk("reset count", int'(count), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset wrap", int'(wrap_cnt), 0);
    chk("reset err", int'(err), 0);
    reset = 1'b0;

`ifndef DECADE_SEQ_PRESCALE_EN
    add(1, 0, 0, 0, 4'd0, 0, 4'd1, 1, 0, 8'd0, 0);
    for (int i = 2; i <= 10; i++)
      add(0, 0, 0, 0, 4'd0, 0, 4'(i), 1, 0, 8'd0, 0);
    add(0, 0, 0, 0, 4'd0, 0, 4'd10, 0, 1, 8'd0, 0);
    add(0, 0, 0, 0, 4'd0, 0, 4'd1, 0, 0, 8'd0, 0);
    add(0, 0, 0, 1, 4'd7, 0, 4'd7, 0, 0, 8'd0, 0);
    add(1, 0, 0, 0, 4'd0, 0, 4'd7, 1, 0, 8'd0, 0);
    add(0, 0, 0, 0, 4'd0, 0, 4'd8, 1, 0, 8'd0, 0);
    add(0, 0, 0, 0, 4'd0, 0, 4'd9, 1, 0, 8'd0, 0);
    add(0, 0, 0, 0, 4'd0, 0, 4'd10, 1, 0, 8'd0, 0);
    add(0, 0, 0, 0, 4'd0, 0, 4'd10, 0, 1, 8'd0, 0);
    add(0, 0, 0, 0, 4'd0, 0, 4'd1, 0, 0, 8'd0, 0);
    add(0, 0, 0, 1, 4'd0, 0, 4'd1, 0, 0, 8'd0, 1);
    add(0, 0, 0, 1, 4'd11, 0, 4'd1, 0, 0, 8'd0, 1);
    add(1, 1, 0, 0, 4'd0, 0, 4'd1, 0, 0, 8'd0, 1);
    add(1, 0, 0, 0, 4'd0, 0, 4'd1, 1, 0, 8'd0, 0);
    add(0, 1, 0, 0, 4'd0, 0, 4'd1, 0, 0, 8'd0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].ld,
          tbl[i].lv, tbl[i].ar);
      chk($sformatf("vec%0d count", i), int'(count), int'(tbl[i].ec));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].eb));
      chk($sformatf("vec%0d done", i), int'(done), int'(tbl[i].ed));
      chk($sformatf("vec%0d wrap", i), int'(wrap_cnt), int'(tbl[i].ew));
      chk($sformatf("vec%0d err", i), int'(err), int'(tbl[i].ee));
    end

    cycm("ar start", 1, 0, 0, 0, 4'd0, 1);
    for (int i = 0; i < 25; i++) begin
      cyc(0, 0, 0, 0, 4'd0, 1);
      chk("ar no done", int'(done), 0);
    end
    chk("ar count", int'(count), 6);
    chk("ar wrap", int'(wrap_cnt), 2);
    cycm("ar stop", 0, 1, 0, 0, 4'd0, 1);
    cycm("ar restart", 1, 0, 0, 0, 4'd0, 1);
    chk("ar wrap cleared", int'(wrap_cnt), 0);
    cycm("ar stop2", 0, 1, 0, 0, 4'd0, 0);

    cycm("p start", 1, 0, 0, 0, 4'd0, 0);
    for (int i = 0; i < 4; i++) cycm("p run", 0, 0, 0, 0, 4'd0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 4'd0, 0);
      chk("p hold count", int'(count), 5);
      chk("p hold busy", int'(busy), 1);
    end
    cyc(0, 0, 1, 1, 4'd3, 0);
    chk("p load", int'(count), 3);
    cyc(0, 0, 0, 0, 4'd0, 0);
    chk("p resume", int'(count), 3);
    cyc(0, 0, 0, 0, 4'd0, 0);
    chk("p next inc", int'(count), 4);
    for (int i = 0; i < 4; i++) cycm("s run", 0, 0, 0, 0, 4'd0, 0);
    chk("s at 8", int'(count), 8);
    cyc(0, 1, 0, 0, 4'd0, 0);
    chk("s count", int'(count), 1);
    chk("s busy", int'(busy), 0);
    chk("s done", int'(done), 0);
    cycm("s after", 0, 0, 0, 0, 4'd0, 0);

    cycm("r start", 1, 0, 0, 0, 4'd0, 1);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 4'd0, 1);
    chk("r pre count", int'(count), 6);
    chk("r pre wrap", int'(wrap_cnt), 1);
    mid_reset("r");
`else
    cycm("ps start", 1, 0, 0, 0, 4'd0, 0);
    for (int i = 1; i <= 8; i++) begin
      cycm("ps run", 0, 0, 0, 0, 4'd0, 0);
      if (i == 3) chk("ps hold", int'(count), 1);
      if (i == 4) chk("ps tick1", int'(count), 2);
      if (i == 8) chk("ps tick2", int'(count), 3);
    end
    cycm("ps stop", 0, 1, 0, 0, 4'd0, 0);
`endif

    begin
      bit ar = 0;
      for (int n = 0; n < 900; n++) begin
        if ($urandom_range(0, 49) == 0) ar = ~ar;
        cycm("rnd",
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 29) == 0,
             $urandom_range(0, 6) == 0,
             $urandom_range(0, 4) == 0,
             4'($urandom_range(0, 15)), ar);
        if (n % 200 == 199) mid_reset("rnd");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
